ifmap_spad_ctrl: RTL
====================

// Module: ifmap_spad_ctrl
// PURPOSE
//  Sequencer on the far side of the PE's 16x8b ifmap scratchpad. Fills the spad from the NoC
//  ifmap stream (valid/ready), then replays it to the MAC datapath as sliding 1-D windows
//  (row-stationary order: all taps of window 0, then window 1, ...). One run per start pulse.
// PARAMETERS
//  DATA_W  8   ifmap element width
//  DEPTH   16  spad entries
//  ADDR_W  4   log2(DEPTH)
// PORTS
//  clk          in   1       clock, all flops rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  start        in   1       1-cycle pulse; begins a run (sampled in IDLE only)
//  row_len      in   5       ifmap elements in row, legal 1..DEPTH; latched on start
//  filt_w       in   4       filter taps per window, legal 1..row_len; latched on start
//  stride       in   2       window step, legal 1..3; latched on start
//  in_valid     in   1       NoC ifmap element valid
//  in_ready     out  1       ctrl accepts element (FILL state only)
//  in_data      in   DATA_W  NoC ifmap element
//  spad_wr      out  1       spad write strobe
//  spad_rd      out  1       spad read strobe; spad_rdata valid one cycle later
//  spad_addr    out  ADDR_W  spad address
//  spad_wdata   out  DATA_W  spad write data (= in_data)
//  spad_rdata   in   DATA_W  spad registered read data
//  out_valid    out  1       window tap valid to MAC
//  out_ready    in   1       MAC accepts tap
//  out_data     out  DATA_W  tap value
//  out_last     out  1       tap is last of its window
//  busy         out  1       state != IDLE
//  done         out  1       1-cycle pulse, run complete
//  err          out  1       1-cycle pulse, start with illegal params
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, all pointers/counters 0, all outputs 0, out FIFO empty.
//  - States IDLE -> FILL -> READ -> DONE -> IDLE.
//  - IDLE: start with legal params -> latch, FILL next cycle. Illegal (row_len 0 or >DEPTH,
//    filt_w 0 or >row_len, stride 0) -> err=1 next cycle, stay IDLE. start outside IDLE ignored.
//  - FILL: in_ready=1. Each in_valid&in_ready: spad_wr=1 same cycle, spad_addr=wr_ptr,
//    wr_ptr++. After row_len-th accept -> READ next cycle. No wrap: wr_ptr never passes row_len-1.
//  - READ: nwin = (row_len-filt_w)/stride + 1 (integer div). Issue addr = base+tap;
//    tap 0..filt_w-1, then tap=0, base+=stride, until nwin windows issued.
//  - Read credit: 2-entry output FIFO; spad_rd issued only if fifo_count + pending < 2
//    (pending = read issued last cycle). Sustains 1 tap/cycle with out_ready held high;
//    first out_valid 2 cycles after first spad_rd. out_last travels with its tap.
//  - out_valid = FIFO non-empty; pop on out_valid&out_ready; out_data/out_last stable while
//    out_valid&!out_ready.
//  - spad_wr and spad_rd never high in the same cycle; spad_addr=0 when neither asserted.
//  - READ -> DONE when all reads issued, none pending, FIFO empty. DONE: done=1 one cycle -> IDLE.
//  - Address arithmetic: base+tap <= row_len-1 always (guaranteed by nwin); 5-bit internal math.
// STRUCTURE
//  - Shared pkg pe_pkg: state enum (IDLE/FILL/READ/DONE), DATA_W, SPAD_DEPTH, SPAD_ADDR_W.
//  - Sub-module: spad_out_fifo (2-entry, DATA_W+1 wide, count output) instantiated once.
//  - FSM, write pointer, window/tap counters and credit logic stay in this module.
// TESTING
//  1. Reset mid-READ (rst_n low 1 cycle) -> next cycle busy=0, out_valid=0, spad_rd=0.
//  2. row_len=5, filt_w=3, stride=1, data 10..14, out_ready=1 -> taps 10,11,12|11,12,13|12,13,14,
//     out_last on 12,13,14; 9 taps back-to-back; done 1 pulse.
//  3. row_len=16, filt_w=4, stride=3, data 0..15 -> 5 windows bases 0,3,6,9,12; last tap=15.
//  4. Same as 2 with out_ready toggling 1,0,0,1 -> tap order unchanged, no loss/dup, data stable
//     while stalled, FIFO never >2.
//  5. in_valid gapped (1 every 3 cycles) during FILL -> spad_wr only on handshakes, addrs 0..4.
//  6. start with filt_w=6,row_len=5 -> err pulse, busy stays 0; start during READ ignored.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared PE definitions: scratchpad geometry, ifmap element width and sequencer states.
package pe_pkg;

   localparam int DATA_W      = 8;
   localparam int SPAD_DEPTH  = 16;
   localparam int SPAD_ADDR_W = 4;
   localparam int ROW_W       = SPAD_ADDR_W + 1;

   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(SPAD_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_READ,
      ST_DONE
   } state_t;

   // A run is only accepted when every window fits inside the row and the step is non-zero.
   function automatic logic params_legal(input logic [ROW_W-1:0]       rl,
                                         input logic [SPAD_ADDR_W-1:0] fw,
                                         input logic [1:0]             st);
      return (rl != '0) && (rl <= ROW_MAX) && (fw != '0) &&
             ({1'b0, fw} <= rl) && (st != 2'd0);
   endfunction

endpackage

// File: rtl/ifmap_spad_ctrl_if.sv
// Bundles the NoC ifmap stream, the scratchpad port and the MAC tap stream of the ifmap sequencer.
interface ifmap_spad_ctrl_if;
   import pe_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_W-1:0]      in_data;

   logic                   spad_wr;
   logic                   spad_rd;
   logic [SPAD_ADDR_W-1:0] spad_addr;
   logic [DATA_W-1:0]      spad_wdata;
   logic [DATA_W-1:0]      spad_rdata;

   logic                   out_valid;
   logic                   out_ready;
   logic [DATA_W-1:0]      out_data;
   logic                   out_last;

   modport master (
      input  in_valid, in_data, spad_rdata, out_ready,
      output in_ready, spad_wr, spad_rd, spad_addr, spad_wdata,
      output out_valid, out_data, out_last
   );

   modport slave (
      output in_valid, in_data, spad_rdata, out_ready,
      input  in_ready, spad_wr, spad_rd, spad_addr, spad_wdata,
      input  out_valid, out_data, out_last
   );

endinterface

// File: rtl/spad_out_fifo.sv
// Two-entry tap FIFO between the registered scratchpad read port and the MAC.
module spad_out_fifo
   import pe_pkg::*;
#(
   parameter int W = DATA_W + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_idx;
   logic         rd_idx;

   // The controller's read credit guarantees no push when full and no pop when empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mem[i] <= '0;
         end
         wr_idx <= 1'b0;
         rd_idx <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_idx] <= push_data;
            wr_idx      <= ~wr_idx;
         end
         if (pop) begin
            rd_idx <= ~rd_idx;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign pop_data = mem[rd_idx];

endmodule

// File: rtl/ifmap_spad_ctrl.sv
// Ifmap scratchpad sequencer: fills the spad from the NoC stream, then replays it to the MAC
// as sliding 1-D windows (all taps of window 0, then window 1, ...).
module ifmap_spad_ctrl
   import pe_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [ROW_W-1:0]       row_len,
   input  logic [SPAD_ADDR_W-1:0] filt_w,
   input  logic [1:0]             stride,
   ifmap_spad_ctrl_if.master      bus,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   state_t                 state;
   state_t                 state_nx;
   logic [ROW_W-1:0]       row_len_q;
   logic [SPAD_ADDR_W-1:0] filt_w_q;
   logic [1:0]             stride_q;
   logic [SPAD_ADDR_W-1:0] wr_ptr;
   logic [SPAD_ADDR_W-1:0] base;
   logic [SPAD_ADDR_W-1:0] tap;
   logic                   issue_done;
   logic                   rd_q;
   logic                   rd_last_q;
   logic                   err_q;

   logic                   start_ok;
   logic                   fill_acc;
   logic                   last_fill;
   logic                   rd_go;
   logic                   last_tap;
   logic                   win_end;
   logic                   pop;
   logic [1:0]             fifo_count;
   logic [2:0]             occ;
   logic [DATA_W:0]        fifo_q;

   assign start_ok  = params_legal(row_len, filt_w, stride);
   assign fill_acc  = (state == ST_FILL) && bus.in_valid;
   assign last_fill = ({1'b0, wr_ptr} == (row_len_q - 5'd1));
   assign last_tap  = (tap == (filt_w_q - 4'd1));

   // The next window would overrun the row: equivalent to having issued (row_len-filt_w)/stride+1 windows.
   assign win_end = ({2'b00, base} + {4'b0000, stride_q} + {2'b00, filt_w_q}) > {1'b0, row_len_q};

   // Credit counts a pop in this very cycle so a held-high out_ready sustains one tap per cycle.
   assign pop   = bus.out_valid && bus.out_ready;
   assign occ   = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, rd_q};
   assign rd_go = (state == ST_READ) && !issue_done && (occ < 3'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (start && start_ok) state_nx = ST_FILL;
         ST_FILL: if (fill_acc && last_fill) state_nx = ST_READ;
         ST_READ: if (issue_done && !rd_q && (fifo_count == 2'd0)) state_nx = ST_DONE;
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_len_q  <= '0;
         filt_w_q   <= '0;
         stride_q   <= '0;
         wr_ptr     <= '0;
         base       <= '0;
         tap        <= '0;
         issue_done <= 1'b0;
         rd_q       <= 1'b0;
         rd_last_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         err_q     <= (state == ST_IDLE) && start && !start_ok;
         rd_q      <= rd_go;
         rd_last_q <= rd_go && last_tap;
         if ((state == ST_IDLE) && start && start_ok) begin
            row_len_q  <= row_len;
            filt_w_q   <= filt_w;
            stride_q   <= stride;
            wr_ptr     <= '0;
            base       <= '0;
            tap        <= '0;
            issue_done <= 1'b0;
         end
         if (fill_acc && !last_fill) begin
            wr_ptr <= wr_ptr + 4'd1;
         end
         if (rd_go) begin
            if (last_tap) begin
               tap <= '0;
               if (win_end) begin
                  issue_done <= 1'b1;
               end else begin
                  base <= base + {2'b00, stride_q};
               end
            end else begin
               tap <= tap + 4'd1;
            end
         end
      end
   end

   spad_out_fifo #(.W(DATA_W + 1)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rd_q),
      .push_data ({rd_last_q, bus.spad_rdata}),
      .pop       (pop),
      .pop_data  (fifo_q),
      .count     (fifo_count)
   );

   assign bus.in_ready   = (state == ST_FILL);
   assign bus.spad_wr    = fill_acc;
   assign bus.spad_rd    = rd_go;
   assign bus.spad_addr  = fill_acc ? wr_ptr : (rd_go ? (base + tap) : '0);
   assign bus.spad_wdata = fill_acc ? bus.in_data : '0;
   assign bus.out_valid  = (fifo_count != 2'd0);
   assign bus.out_data   = bus.out_valid ? fifo_q[DATA_W-1:0] : '0;
   assign bus.out_last   = bus.out_valid && fifo_q[DATA_W];

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);
   assign err  = err_q;

endmodule
